// File: rtl/md_unit_if.sv
// E-stage multiply/divide port bundle: operand/op issue from the pipeline, HI/LO and stall status back.
interface md_unit_if;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_busy;
    logic        md_stall_req;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    modport master (
        output md_start, md_op, md_a, md_b,
        input  md_busy, md_stall_req, md_hi, md_lo
    );

    modport slave (
        input  md_start, md_op, md_a, md_b,
        output md_busy, md_stall_req, md_hi, md_lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/multu/div/divu with HI/LO registers; mthi/mtlo land in one edge.
// Busy for MULT_CYCLES/DIV_CYCLES; md_stall_req holds md-class instructions in D, starts during RUN are dropped.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    md_unit_if.slave md
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic        latch;
    logic [31:0] hi_q, lo_q, hi_nxt, lo_nxt;

    logic [63:0] prod;
    logic        sgn;
    logic [31:0] ua, ub, ub_safe, uq, ur, quo, rem;

    // Result datapath works only on latched operands, so E-stage inputs are free to change during RUN.
    always_comb begin
        prod = op_q[0] ? ({32'b0, a_q} * {32'b0, b_q})
                       : ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q});
        sgn     = ~op_q[0];
        ua      = (sgn & a_q[31]) ? -a_q : a_q;
        ub      = (sgn & b_q[31]) ? -b_q : b_q;
        ub_safe = (ub == 32'd0) ? 32'd1 : ub;
        uq      = ua / ub_safe;
        ur      = ua % ub_safe;
        quo     = (sgn & (a_q[31] ^ b_q[31])) ? -uq : uq;
        rem     = (sgn & a_q[31]) ? -ur : ur;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        case (state)
            IDLE: begin
                if (md.md_start) begin
                    case (md.md_op)
                        3'd0, 3'd1: begin
                            latch     = 1'b1;
                            cnt_nxt   = 16'(MULT_CYCLES - 1);
                            state_nxt = RUN;
                        end
                        3'd2, 3'd3: begin
                            latch     = 1'b1;
                            cnt_nxt   = 16'(DIV_CYCLES - 1);
                            state_nxt = RUN;
                        end
                        3'd4:    hi_nxt = md.md_a;
                        3'd5:    lo_nxt = md.md_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == 16'd0) begin
                    state_nxt = IDLE;
                    if (!op_q[1]) begin
                        {hi_nxt, lo_nxt} = prod;
                    end else if (b_q != 32'd0) begin
                        hi_nxt = rem;
                        lo_nxt = quo;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 16'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= 2'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            if (latch) begin
                a_q  <= md.md_a;
                b_q  <= md.md_b;
                op_q <= md.md_op[1:0];
            end
        end
    end

    assign md.md_busy      = (state == RUN);
    assign md.md_stall_req = (state == RUN) | (md.md_start & ~md.md_op[2]);
    assign md.md_hi        = hi_q;
    assign md.md_lo        = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table of ops with hand-computed HI/LO and busy lengths, plus ignore/reset sequences.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    md_unit_if mif();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issues one instruction, returns how many cycles md_busy stayed high and whether HI/LO moved mid-run.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, output int cyc, output logic moved);
        logic [31:0] hi0, lo0;
        hi0 = mif.md_hi;
        lo0 = mif.md_lo;
        moved = 1'b0;
        @(negedge clk);
        mif.md_start = 1'b1;
        mif.md_op    = op;
        mif.md_a     = a;
        mif.md_b     = b;
        #1;
        chk({tag, " stall_req"}, 32'(mif.md_stall_req), (op < 3'd4) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        mif.md_start = 1'b0;
        mif.md_a     = ~a;
        mif.md_b     = b + 32'd1;
        cyc = 0;
        while (mif.md_busy && cyc < 200) begin
            if (mif.md_hi !== hi0 || mif.md_lo !== lo0) moved = 1'b1;
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          cyc;
        logic        moved;
        logic        bad;

        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd5, 32'h00001234, 32'd0,        32'h00000001, 32'h00001234, 0};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
        vecs[5]  = '{3'd4, 32'h0000AAAA, 32'd0,        32'h0000AAAA, 32'h7FFFFFFC, 0};
        vecs[6]  = '{3'd5, 32'h00005555, 32'd0,        32'h0000AAAA, 32'h00005555, 0};
        vecs[7]  = '{3'd2, 32'd9,        32'd0,        32'h0000AAAA, 32'h00005555, 10};
        vecs[8]  = '{3'd3, 32'd5,        32'd0,        32'h0000AAAA, 32'h00005555, 10};
        vecs[9]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[10] = '{3'd6, 32'h00001234, 32'd1,        32'h00000000, 32'h80000000, 0};
        vecs[11] = '{3'd0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 5};
        vecs[12] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[13] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};

        reset        = 1'b1;
        mif.md_start = 1'b0;
        mif.md_op    = 3'd0;
        mif.md_a     = 32'd0;
        mif.md_b     = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset busy",  32'(mif.md_busy), 32'd0);
        chk("reset stall", 32'(mif.md_stall_req), 32'd0);
        chk("reset hi",    mif.md_hi, 32'd0);
        chk("reset lo",    mif.md_lo, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("v%0d", i), cyc, moved);
            chk($sformatf("v%0d busy_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            chk($sformatf("v%0d hold_in_run", i), 32'(moved), 32'd0);
            chk($sformatf("v%0d hi", i), mif.md_hi, vecs[i].hi);
            chk($sformatf("v%0d lo", i), mif.md_lo, vecs[i].lo);
        end

        // mult 6x7 with an mthi pulse in busy cycle 2 that must be dropped.
        @(negedge clk);
        mif.md_start = 1'b1;
        mif.md_op    = 3'd0;
        mif.md_a     = 32'd6;
        mif.md_b     = 32'd7;
        @(posedge clk);
        #1;
        mif.md_start = 1'b0;
        cyc = 0;
        while (mif.md_busy && cyc < 200) begin
            cyc++;
            if (cyc == 2) begin
                @(negedge clk);
                mif.md_start = 1'b1;
                mif.md_op    = 3'd4;
                mif.md_a     = 32'h0000DEAD;
                #1;
                chk("ignore stall_req", 32'(mif.md_stall_req), 32'd1);
            end
            @(posedge clk);
            #1;
            mif.md_start = 1'b0;
        end
        chk("ignore busy_cycles", 32'(cyc), 32'd5);
        chk("ignore hi", mif.md_hi, 32'd0);
        chk("ignore lo", mif.md_lo, 32'd42);

        // divu 100/3 aborted by reset in busy cycle 4.
        @(negedge clk);
        mif.md_start = 1'b1;
        mif.md_op    = 3'd3;
        mif.md_a     = 32'd100;
        mif.md_b     = 32'd3;
        @(posedge clk);
        #1;
        mif.md_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort busy_before", 32'(mif.md_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort busy", 32'(mif.md_busy), 32'd0);
        chk("abort hi",   mif.md_hi, 32'd0);
        chk("abort lo",   mif.md_lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (mif.md_busy || mif.md_hi !== 32'd0 || mif.md_lo !== 32'd0) bad = 1'b1;
        end
        chk("abort no_late_update", 32'(bad), 32'd0);

        run_op(3'd0, 32'd3, 32'd3, "post", cyc, moved);
        chk("post busy_cycles", 32'(cyc), 32'd5);
        chk("post hi", mif.md_hi, 32'd0);
        chk("post lo", mif.md_lo, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multiply/divide unit in the E stage, beside the ALU. It takes forwarded rs/rt operands and executes mult, multu, div and divu over several cycles, plus immediate mthi/mtlo writes. It holds the HI/LO architectural registers that mfhi/mflo read in E. It also raises a stall request that the hazard unit uses to hold any md-class instruction in D while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
md_start  input  1  E-stage instruction is md-class this cycle (single-cycle pulse per instruction)
md_op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo, 6/7 reserved (no-op)
md_a  input  32  forwarded rs value (MF_RS_E)
md_b  input  32  forwarded rt value (MF_RT_E)
md_busy  output  1  multi-cycle operation in progress
md_stall_req  output  1  combinational md_busy | (md_start & md_op<=3)
md_hi  output  32  current HI register
md_lo  output  32  current LO register

Behaviour:
- Reset (async): md_busy=0, HI=0, LO=0, counter=0, latched operands/op cleared. Any operation in flight is aborted and produces no HI/LO update.
- State machine IDLE/RUN, encoded by md_busy.
- IDLE, md_start=1 with op 0..3 at edge T:
  - latch md_a, md_b, md_op;
  - load counter with MULT_CYCLES-1 or DIV_CYCLES-1;
  - md_busy=1 from T through the edge that ends the operation.
  - md_busy is high for exactly MULT_CYCLES or DIV_CYCLES clock cycles.
- RUN: counter decrements each edge. At the edge where counter==0:
  - HI/LO take the result;
  - md_busy drops;
  - the new values are visible on md_hi/md_lo in the following cycle.
- Result is computed from the latched operands only; input changes during RUN have no effect.
- mthi/mtlo in IDLE: HI (or LO) <= md_a at that edge. No busy, no latency beyond one edge.
- md_start in RUN (any op): ignored. HI/LO and the counter are unaffected. This cannot occur architecturally because the hazard unit stalls on md_stall_req; it is specified for robustness.
- Reserved op (6/7) with md_start: no effect.
- Arithmetic:
  - mult: signed 32x32 -> 64, {HI,LO}=product.
  - multu: unsigned 64-bit product.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (div or divu): HI and LO unchanged. Busy timing is still DIV_CYCLES.
- md_hi/md_lo hold the old values throughout RUN. mfhi/mflo must be stalled by the hazard unit while md_stall_req=1; this block does not forward in-flight results.
- md_stall_req is combinational so that an md-class instruction in D stalls in the same cycle its predecessor starts in E.
- Implementation is free: a behavioural *,/,% plus a delay counter, or an iterative datapath. Only cycle timing and results are normative.

Test Plan:
- mult md_a=0xFFFFFFFD (-3), md_b=5: md_busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; md_stall_req=1 in the start cycle.
- multu 0xFFFFFFFF x 2: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. Then mtlo md_a=0x1234: LO=0x00001234 one edge later, md_busy stays 0.
- div -7/2: busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 0xFFFFFFF9/2: LO=0x7FFFFFFC, HI=1.
- Preload HI=0xAAAA, LO=0x5555 via mthi/mtlo, then div 9/0: busy 10 cycles, HI=0xAAAA and LO=0x5555 unchanged. div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Start mult 6x7, then pulse md_start with mthi md_a=0xDEAD at cycle 2 of busy: ignored; final HI=0, LO=42; busy length unchanged.
- Start divu 100/3, assert reset at cycle 4: md_busy, HI and LO go to 0 immediately (asynchronously). After reset release, no later HI/LO update occurs.
